// File: rtl/led_step_scheduler.sv
// Turns debounced button presses into single-cycle inc/dec steps for the LED counter,
// with optional hold-to-auto-repeat (enabled by defining LED_AUTO_REPEAT_EN).
module led_step_scheduler #(
    parameter int B             = 4,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int SATURATE      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         add_level,
    input  logic         sub_level,
    input  logic         add_edge,
    input  logic         sub_edge,
    output logic         inc,
    output logic         dec,
    output logic [B-1:0] count,
    output logic [1:0]   state
);

    logic step_req;
    logic step_dir;  // 0 = add, 1 = sub
    logic blocked;
    logic inc_nxt;
    logic dec_nxt;

`ifdef LED_AUTO_REPEAT_EN
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10
    } state_t;

    state_t        state_q, state_nxt;
    logic          dir_q, dir_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          sel_level;
    logic          opp_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            timer   <= '0;
        end else begin
            state_q <= state_nxt;
            dir_q   <= dir_nxt;
            timer   <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        dir_nxt   = dir_q;
        timer_nxt = timer;
        step_req  = 1'b0;
        step_dir  = dir_q;
        sel_level = dir_q ? sub_level : add_level;
        opp_edge  = dir_q ? add_edge : sub_edge;
        case (state_q)
            IDLE: begin
                timer_nxt = '0;
                // simultaneous presses cancel each other
                if (add_edge ^ sub_edge) begin
                    state_nxt = HOLD;
                    dir_nxt   = sub_edge;
                    step_req  = 1'b1;
                    step_dir  = sub_edge;
                end
            end
            HOLD, REPEAT: begin
                if (!sel_level || opp_edge) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if ((state_q == HOLD   && timer == TW'(HOLD_CYCLES - 1)) ||
                             (state_q == REPEAT && timer == TW'(REPEAT_CYCLES - 1))) begin
                    state_nxt = REPEAT;
                    timer_nxt = '0;
                    step_req  = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    assign state = state_q;
`else
    // levels only matter for auto-repeat
    wire unused_levels = ^{add_level, sub_level};

    assign step_req = add_edge ^ sub_edge;
    assign step_dir = sub_edge;
    assign state    = 2'b00;
`endif

    // saturation suppresses the pulse but leaves FSM timing untouched
    assign blocked = (SATURATE != 0) && (step_dir ? (count == '0) : (count == '1));
    assign inc_nxt = step_req && !step_dir && !blocked;
    assign dec_nxt = step_req &&  step_dir && !blocked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc   <= 1'b0;
            dec   <= 1'b0;
            count <= '0;
        end else begin
            inc <= inc_nxt;
            dec <= dec_nxt;
            if (inc_nxt)
                count <= count + B'(1);
            else if (dec_nxt)
                count <= count - B'(1);
        end
    end

endmodule

// File: tb/tb_led_step_scheduler.sv
// Bench for led_step_scheduler: table of button presses plus abort/reset sequences,
// expected step pulses queued at drive time and matched cycle by cycle.
module tb_led_step_scheduler;

    localparam int B    = 4;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic       clk, reset;
    logic       add_level, sub_level, add_edge, sub_edge;
    logic       inc, dec, inc_w, dec_w;
    logic [3:0] count, count_w;
    logic [1:0] state, state_w;

    led_step_scheduler #(.B(B), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .add_level(add_level), .sub_level(sub_level),
        .add_edge(add_edge), .sub_edge(sub_edge), .inc(inc), .dec(dec),
        .count(count), .state(state));

    led_step_scheduler #(.B(B), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .add_level(add_level), .sub_level(sub_level),
        .add_edge(add_edge), .sub_edge(sub_edge), .inc(inc_w), .dec(dec_w),
        .count(count_w), .state(state_w));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic ie;
        logic de;
        int   cyc;
    } ev_t;

    typedef struct {
        logic ae;
        logic se;
        logic la;
        logic ls;
        int   len;
    } vec_t;

    ev_t        sbq[$];
    int         cyc;
    int         tests;
    int         fails;
    logic [3:0] m_cnt, m_cnt_w;

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // advance one clock, sample after the edge and match pulses against the queue
    task automatic tick();
        logic ei, ed;
        ev_t  e;
        @(posedge clk);
        cyc++;
        #1;
        ei = 1'b0;
        ed = 1'b0;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e  = sbq.pop_front();
            ei = e.ie;
            ed = e.de;
        end
        if (inc || dec || ei || ed) begin
            check("inc_pulse", int'(inc), int'(ei));
            check("dec_pulse", int'(dec), int'(ed));
        end
    endtask

    task automatic push_step(int c, logic is_sub);
        ev_t e;
        e.cyc = c;
        if (is_sub) begin
            if (m_cnt != 4'd0) begin
                e.ie = 1'b0; e.de = 1'b1; sbq.push_back(e); m_cnt--;
            end
            m_cnt_w--;
        end else begin
            if (m_cnt != 4'd15) begin
                e.ie = 1'b1; e.de = 1'b0; sbq.push_back(e); m_cnt++;
            end
            m_cnt_w++;
        end
    endtask

    // steps expected from a press at cycle base with the level held len cycles
    task automatic plan(logic is_sub, int len, int base);
        push_step(base + 1, is_sub);
`ifdef LED_AUTO_REPEAT_EN
        for (int p = HOLD + 1; p <= len; p += REP)
            push_step(base + p, is_sub);
`endif
    endtask

    task automatic run_vec(vec_t v, int idx);
        int e0;
        e0 = cyc;
        add_edge  = v.ae;
        sub_edge  = v.se;
        add_level = v.la;
        sub_level = v.ls;
        if (v.ae ^ v.se)
            plan(v.se, v.len, e0);
        tick();
        add_edge = 1'b0;
        sub_edge = 1'b0;
        while (cyc < e0 + v.len)
            tick();
        add_level = 1'b0;
        sub_level = 1'b0;
        repeat (4) tick();
        check($sformatf("vec%0d_count", idx), int'(count), int'(m_cnt));
        check($sformatf("vec%0d_count_wrap", idx), int'(count_w), int'(m_cnt_w));
        check($sformatf("vec%0d_state", idx), int'(state), 0);
        check($sformatf("vec%0d_pending", idx), sbq.size(), 0);
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        tests = 0; fails = 0; cyc = 0;
        m_cnt = 4'd0; m_cnt_w = 4'd0;
        reset = 1'b1;
        add_level = 1'b0; sub_level = 1'b0; add_edge = 1'b0; sub_edge = 1'b0;

        //            ae    se    la    ls    len
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 20};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 60};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 30};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 80};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 20};

        repeat (2) tick();
        check("rst_count", int'(count), 0);
        check("rst_state", int'(state), 0);
        check("rst_inc", int'(inc), 0);
        check("rst_dec", int'(dec), 0);
        check("rst_count_wrap", int'(count_w), 0);

        // first press lands on the very first edge after release
        reset = 1'b0;
        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], i);

`ifdef LED_AUTO_REPEAT_EN
        // opposite button aborts a running sub auto-repeat
        e0 = cyc;
        sub_edge = 1'b1; sub_level = 1'b1;
        plan(1'b1, 12, e0);
        tick();
        sub_edge = 1'b0;
        check("abort_state_hold", int'(state), 1);
        while (cyc < e0 + 10) tick();
        check("abort_state_repeat", int'(state), 2);
        tick();
        add_edge = 1'b1;
        tick();
        add_edge = 1'b0;
        check("abort_state_idle", int'(state), 0);
        while (cyc < e0 + 20) tick();
        sub_level = 1'b0;
        repeat (3) tick();
        check("abort_count", int'(count), int'(m_cnt));
        check("abort_pending", sbq.size(), 0);
`else
        // back-to-back presses each give exactly one step
        e0 = cyc;
        for (int i = 0; i < 3; i++) begin
            add_edge = 1'b1;
            push_step(cyc + 1, 1'b0);
            tick();
        end
        add_edge = 1'b0;
        sub_edge = 1'b1;
        push_step(cyc + 1, 1'b1);
        tick();
        sub_edge = 1'b0;
        repeat (3) tick();
        check("b2b_count", int'(count), int'(m_cnt));
        check("b2b_state", int'(state), 0);
        check("b2b_pending", sbq.size(), 0);
`endif

        // reset in the middle of a held press, level left high afterwards
        e0 = cyc;
        add_edge = 1'b1; add_level = 1'b1;
        plan(1'b0, 10, e0);
        tick();
        add_edge = 1'b0;
        while (cyc < e0 + 10) tick();
`ifdef LED_AUTO_REPEAT_EN
        check("mid_state_repeat", int'(state), 2);
`endif
        reset = 1'b1;
        #1;
        m_cnt = 4'd0; m_cnt_w = 4'd0;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_count_wrap", int'(count_w), 0);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_inc", int'(inc), 0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("post_rst_count", int'(count), 0);
        check("post_rst_state", int'(state), 0);
        e0 = cyc;
        add_edge = 1'b1;
        plan(1'b0, 1, e0);
        tick();
        add_edge = 1'b0; add_level = 1'b0;
        repeat (3) tick();
        check("repress_count", int'(count), int'(m_cnt));
        check("repress_count_wrap", int'(count_w), int'(m_cnt_w));
        check("repress_pending", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_step_scheduler.md
LED_STEP_SCHEDULER -- requirements
Module: led_step_scheduler

Interface
REQ-001 Parameter: B, 4, counter width shared with the LED counter.
REQ-002 Parameter: HOLD_CYCLES, 50_000_000, cycles a button is held before auto-repeat starts (>=2).
REQ-003 Parameter: REPEAT_CYCLES, 10_000_000, cycles between auto-repeat steps (>=2).
REQ-004 Parameter: SATURATE, 1, 1 = clamp at 0 / 2^B-1; 0 = wrap modulo 2^B.
REQ-005 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: add_level, sub_level  input  1 each  debounced button levels.
REQ-008 Port: add_edge, sub_edge  input  1 each  single-cycle rising-edge pulses from the debouncers.
REQ-009 Port: inc, dec  output  1 each  registered single-cycle step pulses to the LED counter.
REQ-010 Port: count  output  B  shadow of the LED counter value, updated with every issued step.
REQ-011 Port: state  output  2  FSM state: 00 IDLE, 01 HOLD, 10 REPEAT.

Function
REQ-012 inc and dec SHALL never be high in the same cycle; each pulse is exactly one cycle wide.
REQ-013 FSM states: IDLE, HOLD, REPEAT. A direction register (ADD/SUB) is latched on leaving IDLE.
REQ-014 IDLE: add_edge alone in cycle N -> inc high in cycle N+1, direction=ADD, state=HOLD in N+1, hold timer cleared. sub_edge is symmetric.
REQ-015 IDLE: add_edge and sub_edge in the same cycle -> no pulse, remain IDLE (cancel).
REQ-016 HOLD: timer increments each cycle while the selected level is high; on the cycle it reaches HOLD_CYCLES-1 -> step pulse next cycle, state=REPEAT, timer cleared.
REQ-017 REPEAT: step pulse every REPEAT_CYCLES cycles while the selected level stays high.
REQ-018 HOLD/REPEAT: selected level low -> IDLE next cycle, no pulse, timer cleared.
REQ-019 HOLD/REPEAT: edge of the opposite button -> abort to IDLE next cycle, no pulse; a new press is required.
REQ-020 count increments on each inc and decrements on each dec, registered in the same cycle the pulse is driven.
REQ-021 SATURATE=1: an inc at count=2^B-1, or a dec at count=0, is suppressed (no pulse, count unchanged); FSM timing continues.
REQ-022 SATURATE=0: count wraps 2^B-1 -> 0 on inc and 0 -> 2^B-1 on dec; pulses are always issued.
REQ-023 Timer width: ceil(log2(max(HOLD_CYCLES, REPEAT_CYCLES))) bits; timer never exceeds its terminal value.

Reset
REQ-024 reset asserted -> immediately: state=IDLE, inc=0, dec=0, count=0, timer=0, direction=ADD.
REQ-025 reset mid-HOLD/REPEAT aborts the sequence; after release, a held level without a new edge produces no pulse.
REQ-026 First edge accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-027 Macro LED_AUTO_REPEAT_EN defined: HOLD and REPEAT behave per REQ-016..REQ-019.
REQ-028 Macro LED_AUTO_REPEAT_EN undefined: the HOLD/REPEAT states and the timer are not built; every edge yields exactly one step, state stays 00, and REQ-015 and REQ-021/022 still apply.

Verification (B=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, SATURATE=1, LED_AUTO_REPEAT_EN defined)
REQ-029 Reset, one add_edge, level dropped after 3 cycles -> exactly one inc, count=1, state returns to 00.
REQ-030 add_level held 20 cycles after add_edge -> inc at edge+1, edge+9, edge+13, edge+17; count=4.
REQ-031 add_edge and sub_edge in the same cycle from IDLE -> no inc/dec, count unchanged.
REQ-032 count=15, add held for 30 cycles -> no inc issued, count stays 15; SATURATE=0 -> count wraps to 0 on the first inc.
REQ-033 sub held in REPEAT, add_edge pulsed -> no pulse, IDLE next cycle, dec stops.
REQ-034 reset asserted during REPEAT with add_level still high -> count=0 at once, no inc after release until a new add_edge.
